fetch_sequencer: RTL and testbench

//  Sequences instruction fetch from the byte-wide instruction memory (IMem).

---
 rtl/fetch_sequencer_pkg.sv | 21 ++
 rtl/fetch_sequencer_imem_byte_gather.sv | 69 ++++++
 rtl/fetch_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer and its byte gatherer.
// FETCH_PERF_CNT_EN (see fetch_sequencer) adds optional performance counters.
package fetch_sequencer_pkg;

    localparam int unsigned InstrW        = 32;
    localparam int unsigned BytesPerInstr = 4;
    localparam logic [10:0] HaltOpc       = 11'h7FF;

    typedef enum logic [2:0] {
        FsIdle,
        FsFetch,
        FsIssue,
        FsDrain,
        FsHalt
    } fetch_state_e;

    function automatic logic is_halt(logic [InstrW-1:0] instr);
        return instr[InstrW-1 -: 11] == HaltOpc;
    endfunction

endpackage

// File: rtl/fetch_sequencer_imem_byte_gather.sv
// Byte gatherer: issues four sequential IMem byte reads and assembles a little-endian word.
// Read data returns one cycle after each request, so beats 1-4 capture bytes 0-3.
module fetch_sequencer_imem_byte_gather
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned IMEM_AW = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic               abort,
    input  logic [IMEM_AW-1:0] base,
    output logic               imem_rd,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [7:0]         imem_rdata,
    output logic               done,
    output logic [InstrW-1:0]  word
);

    localparam logic [2:0] LastBeat = 3'(BytesPerInstr);

    logic              active_q;
    logic [2:0]        beat_q;
    logic              done_q;
    logic [InstrW-1:0] word_q;
    logic [1:0]        lane;

    always_comb begin
        imem_rd   = active_q && (beat_q != LastBeat);
        imem_addr = imem_rd ? base + IMEM_AW'(beat_q) : '0;
        lane      = 2'(beat_q - 3'd1);
    end

    // go restarts from beat 0 even mid-sequence, so any byte still in flight is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            beat_q   <= '0;
            done_q   <= 1'b0;
            word_q   <= '0;
        end else if (go) begin
            active_q <= 1'b1;
            beat_q   <= '0;
            done_q   <= 1'b0;
        end else if (abort) begin
            active_q <= 1'b0;
            beat_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (active_q) begin
                if (beat_q != 3'd0) begin
                    word_q[{lane, 3'b000} +: 8] <= imem_rdata;
                end
                if (beat_q == LastBeat) begin
                    active_q <= 1'b0;
                    beat_q   <= '0;
                    done_q   <= 1'b1;
                end else begin
                    beat_q <= beat_q + 3'd1;
                end
            end
        end
    end

    assign done = done_q;
    assign word = word_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, gathers 32-bit words from byte-wide IMem,
// hands them to decode, applies redirects and drains to HALT. Option: FETCH_PERF_CNT_EN.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned     PC_W         = 64,
    parameter int unsigned     IMEM_AW      = 12,
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter int unsigned     DRAIN_CYCLES = 5,
    parameter int unsigned     MAX_FETCH    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               imem_rd,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [7:0]         imem_rdata,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [31:0]        if_instr,
    output logic [PC_W-1:0]    if_pc,
    output logic               busy,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]        fetch_count,
    output logic [31:0]        redirect_count,
`endif
    output logic               halted
);

    localparam int unsigned       DrainW    = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DrainW-1:0] DrainInit =
        DrainW'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);

    fetch_state_e      state_q;
    logic [PC_W-1:0]   pc_q;
    logic [31:0]       count_q;
    logic [DrainW-1:0] drain_q;
    logic              if_valid_q;
    logic [InstrW-1:0] if_instr_q;
    logic [PC_W-1:0]   if_pc_q;
    logic              halted_q;

    logic [PC_W-1:0]   redirect_tgt;
    logic              handshake;
    logic              halt_hs;
    logic              redirect_acc;
    logic              limit_hit;
    logic              gather_go;
    logic              gather_done;
    logic [InstrW-1:0] gather_word;
    logic              unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    always_comb begin
        redirect_tgt = {redirect_pc[PC_W-1:2], 2'b00};
        handshake    = (state_q == FsIssue) && if_valid_q && if_ready;
        halt_hs      = handshake && is_halt(if_instr_q);
        // A HALT handshake swallows any coincident redirect.
        redirect_acc = redirect_valid && !halt_hs &&
                       ((state_q == FsFetch) || (state_q == FsIssue));
        limit_hit    = handshake && !halt_hs && (MAX_FETCH != 0) &&
                       ((count_q + 32'd1) == MAX_FETCH);
        gather_go    = ((state_q == FsIdle) && start) ||
                       (redirect_acc && !limit_hit) ||
                       (handshake && !halt_hs && !limit_hit);
    end

    fetch_sequencer_imem_byte_gather #(
        .IMEM_AW (IMEM_AW)
    ) u_gather (
        .clk        (clk),
        .rst        (rst),
        .go         (gather_go),
        .abort      (redirect_acc),
        .base       (pc_q[IMEM_AW-1:0]),
        .imem_rd    (imem_rd),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .done       (gather_done),
        .word       (gather_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FsIdle;
            pc_q       <= RESET_PC;
            count_q    <= '0;
            drain_q    <= '0;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
            halted_q   <= 1'b0;
        end else begin
            unique case (state_q)
                FsIdle: begin
                    if (start) begin
                        state_q <= FsFetch;
                    end
                end
                FsFetch: begin
                    if (redirect_acc) begin
                        pc_q <= redirect_tgt;
                    end else if (gather_done) begin
                        state_q    <= FsIssue;
                        if_valid_q <= 1'b1;
                        if_instr_q <= gather_word;
                        if_pc_q    <= pc_q;
                    end
                end
                FsIssue: begin
                    if (halt_hs) begin
                        state_q    <= FsDrain;
                        drain_q    <= DrainInit;
                        if_valid_q <= 1'b0;
                    end else if (handshake) begin
                        // The instruction is consumed; a coincident redirect picks the next PC.
                        count_q    <= count_q + 32'd1;
                        pc_q       <= redirect_acc ? redirect_tgt
                                                   : pc_q + PC_W'(BytesPerInstr);
                        if_valid_q <= 1'b0;
                        if (limit_hit) begin
                            state_q <= FsDrain;
                            drain_q <= DrainInit;
                        end else begin
                            state_q <= FsFetch;
                        end
                    end else if (redirect_acc) begin
                        pc_q       <= redirect_tgt;
                        if_valid_q <= 1'b0;
                        state_q    <= FsFetch;
                    end
                end
                FsDrain: begin
                    if (drain_q == '0) begin
                        state_q  <= FsHalt;
                        halted_q <= 1'b1;
                    end else begin
                        drain_q <= drain_q - DrainW'(1);
                    end
                end
                FsHalt: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q <= FsIdle;
                end
            endcase
        end
    end

    assign if_valid = if_valid_q;
    assign if_instr = if_instr_q;
    assign if_pc    = if_pc_q;
    assign halted   = halted_q;
    assign busy     = (state_q != FsIdle) && (state_q != FsHalt);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q;
    logic [31:0] redirect_count_q;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count_q    <= '0;
            redirect_count_q <= '0;
        end else begin
            if (handshake && (fetch_count_q != 32'hFFFF_FFFF)) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (redirect_acc && (redirect_count_q != 32'hFFFF_FFFF)) begin
                redirect_count_q <= redirect_count_q + 32'd1;
            end
        end
    end

    assign fetch_count    = fetch_count_q;
    assign redirect_count = redirect_count_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: random IMem contents, random redirects and
// backpressure; a PC-level reference model predicts each handshaken instruction.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        imem_rd;
    logic [11:0] imem_addr;
    logic [7:0]  imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        busy;
    logic        halted;

    fetch_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .imem_rd        (imem_rd),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .busy           (busy),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [4096];

    // Byte memory: data appears the cycle after the request; garbage otherwise.
    always @(posedge clk) begin
        imem_rdata <= imem_rd ? mem[imem_addr] : 8'($urandom);
    end

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } exp_t;

    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [63:0] mpc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [63:0] pc);
        logic [11:0] a;
        a = pc[11:0];
        return {mem[a + 12'd3], mem[a + 12'd2], mem[a + 12'd1], mem[a]};
    endfunction

    function automatic logic [63:0] align(input logic [63:0] t);
        return {t[63:2], 2'b00};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!if_valid && n < 40) begin
            step();
            n++;
        end
        chk("if_valid_timeout", {63'd0, if_valid}, 64'd1);
    endtask

    task automatic handshake(input int bp, input bit redir, input logic [63:0] tgt);
        wait_valid();
        for (int i = 0; i < bp; i++) begin
            if_ready = 1'b0;
            step();
            chk("bp_valid_held", {63'd0, if_valid}, 64'd1);
            chk("bp_no_imem_rd", {63'd0, imem_rd}, 64'd0);
        end
        q.push_back('{instr: word_at(mpc), pc: mpc});
        if_ready       = 1'b1;
        redirect_valid = redir;
        redirect_pc    = tgt;
        step();
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        mpc            = redir ? align(tgt) : mpc + 64'd4;
    endtask

    task automatic fetch_redirect(input int k, input logic [63:0] tgt);
        for (int i = 0; i < k; i++) step();
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        step();
        redirect_valid = 1'b0;
        mpc            = align(tgt);
    endtask

    task automatic issue_redirect(input int bp, input logic [63:0] tgt);
        wait_valid();
        for (int i = 0; i < bp; i++) step();
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        step();
        redirect_valid = 1'b0;
        mpc            = align(tgt);
        chk("issue_redirect_drop", {63'd0, if_valid}, 64'd0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_imem_rd"}, {63'd0, imem_rd}, 64'd0);
        chk({tag, "_imem_addr"}, {52'd0, imem_addr}, 64'd0);
        chk({tag, "_if_valid"}, {63'd0, if_valid}, 64'd0);
        chk({tag, "_if_instr"}, {32'd0, if_instr}, 64'd0);
        chk({tag, "_if_pc"}, if_pc, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_halted"}, {63'd0, halted}, 64'd0);
    endtask

    // Monitor: pop and compare on every handshake, and check issue-stage stability.
    logic        prev_valid = 1'b0;
    logic        prev_hs    = 1'b0;
    logic [31:0] prev_instr;
    logic [63:0] prev_pc;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (prev_hs) chk("valid_after_hs", {63'd0, if_valid}, 64'd0);
            if (prev_valid && !prev_hs && if_valid) begin
                chk("stable_instr", {32'd0, if_instr}, {32'd0, prev_instr});
                chk("stable_pc", if_pc, prev_pc);
            end
            if (if_valid && if_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_handshake", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("if_instr", {32'd0, if_instr}, {32'd0, e.instr});
                    chk("if_pc", if_pc, e.pc);
                end
            end
            prev_valid = if_valid;
            prev_hs    = if_valid && if_ready;
            prev_instr = if_instr;
            prev_pc    = if_pc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst            = 1'b1;
        start          = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        // Keep random words clear of the HALT opcode.
        for (int i = 3; i < 4096; i += 4) if (mem[i] == 8'hFF) mem[i] = 8'h7F;
        mem[0] = 8'h78;
        mem[1] = 8'h56;
        mem[2] = 8'h34;
        mem[3] = 8'h12;

        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("in_reset");
        rst = 1'b0;
        step();
        chk_idle_outputs("after_reset");

        // Start: first read at the reset PC, instruction six edges later.
        mpc   = 64'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_imem_rd", {63'd0, imem_rd}, 64'd1);
        chk("start_imem_addr", {52'd0, imem_addr}, 64'd0);
        chk("start_busy", {63'd0, busy}, 64'd1);
        n = 0;
        while (!if_valid && n < 20) begin
            step();
            n++;
        end
        chk("start_latency", 64'(n), 64'd6);

        // Long backpressure, then the next fetch proceeds at PC 4.
        handshake(10, 1'b0, '0);
        chk("next_imem_rd", {63'd0, imem_rd}, 64'd1);
        chk("next_imem_addr", {52'd0, imem_addr}, 64'd4);

        // Redirect at beat 2 to a misaligned target.
        fetch_redirect(2, 64'h103);
        for (int i = 0; i < 4; i++) begin
            chk("redir_imem_rd", {63'd0, imem_rd}, 64'd1);
            chk("redir_imem_addr", {52'd0, imem_addr}, 64'h100 + 64'(i));
            step();
        end
        handshake(0, 1'b0, '0);

        // Address wrap at the top of IMem; the PC keeps counting.
        fetch_redirect(1, 64'hFFC);
        for (int i = 0; i < 4; i++) begin
            chk("wrap_imem_addr", {52'd0, imem_addr}, 64'hFFC + 64'(i));
            step();
        end
        handshake(0, 1'b0, '0);
        chk("wrap_next_addr", {52'd0, imem_addr}, 64'd0);
        chk("wrap_next_rd", {63'd0, imem_rd}, 64'd1);
        handshake(1, 1'b0, '0);

        // Random traffic.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 2) == 0) begin
                fetch_redirect($urandom_range(0, 5), {$urandom, $urandom});
            end
            if ($urandom_range(0, 4) == 0) begin
                issue_redirect($urandom_range(0, 2), {$urandom, $urandom});
            end
            handshake($urandom_range(0, 3), $urandom_range(0, 4) == 0, {$urandom, $urandom});
        end

        // HALT at PC 8 with a coincident redirect: HALT wins.
        mem[8]  = 8'h00;
        mem[9]  = 8'h00;
        mem[10] = 8'hE0;
        mem[11] = 8'hFF;
        fetch_redirect(0, 64'h9);
        wait_valid();
        q.push_back('{instr: 32'hFFE0_0000, pc: 64'd8});
        if_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        step();
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        chk("drain_busy", {63'd0, busy}, 64'd1);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("halt_timing", {63'd0, halted}, {63'd0, i == 5});
            chk("drain_no_rd", {63'd0, imem_rd}, 64'd0);
            chk("drain_no_valid", {63'd0, if_valid}, 64'd0);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h40;
        start          = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("halt_sticky", {63'd0, halted}, 64'd1);
            chk("halt_no_rd", {63'd0, imem_rd}, 64'd0);
            chk("halt_not_busy", {63'd0, busy}, 64'd0);
        end
        redirect_valid = 1'b0;
        start          = 1'b0;

        // Asynchronous reset mid-fetch.
        rst = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk_idle_outputs("async_reset");
        step();
        rst   = 1'b0;
        mpc   = 64'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_imem_addr", {52'd0, imem_addr}, 64'd0);
        chk("restart_imem_rd", {63'd0, imem_rd}, 64'd1);
        handshake(2, 1'b0, '0);

        repeat (3) step();
        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
